pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit, the successor to the team's flat 32-bit ripple-carry adder. The carry chain is cut into `STAGES` registered slices, so long operands close timing at full clock rate. Sustains one operation per cycle behind a valid/ready handshake on both sides, and adds subtract mode and signed-overflow detection. Sits between operand-producing datapath blocks (ALU front end, accumulators) and their consumers.

---
 rtl/pipelined_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered slices.
// Optional signed-overflow output is built only when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Per-stage registers: valid, carry, partial sum, and the unused operand
   // slices shifted down so the next stage always consumes bits [SW-1:0].
   logic             v_q  [STAGES];
   logic             c_q  [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic [WIDTH-1:0] xr_q [STAGES];
   logic [WIDTH-1:0] yr_q [STAGES];

   logic             f_v  [STAGES];
   logic             f_c  [STAGES];
   logic [WIDTH-1:0] f_s  [STAGES];
   logic [WIDTH-1:0] f_x  [STAGES];
   logic [WIDTH-1:0] f_y  [STAGES];

   logic             n_c  [STAGES];
   logic [WIDTH-1:0] n_s  [STAGES];
   logic [WIDTH-1:0] n_x  [STAGES];
   logic [WIDTH-1:0] n_y  [STAGES];

   logic             ld   [STAGES];

   always_comb begin
      f_v[0] = in_valid;
      f_c[0] = sub ? ~ci : ci;
      f_s[0] = '0;
      f_x[0] = x;
      f_y[0] = sub ? ~y : y;
      for (int k = 1; k < STAGES; k++) begin
         f_v[k] = v_q[k-1];
         f_c[k] = c_q[k-1];
         f_s[k] = s_q[k-1];
         f_x[k] = xr_q[k-1];
         f_y[k] = yr_q[k-1];
      end
   end

   always_comb begin
      logic [SW:0] tmp;
      tmp = '0;
      for (int k = 0; k < STAGES; k++) begin
         tmp = {1'b0, f_x[k][SW-1:0]} + {1'b0, f_y[k][SW-1:0]} + {{SW{1'b0}}, f_c[k]};
         n_c[k] = tmp[SW];
         n_s[k] = f_s[k];
         n_s[k][k*SW +: SW] = tmp[SW-1:0];
         n_x[k] = f_x[k] >> SW;
         n_y[k] = f_y[k] >> SW;
      end
   end

   // Handshake: a beat moves on valid && ready. Stage k loads when it is empty
   // or its beat advances; the last stage advances on out_ready, so bubbles
   // collapse and in_ready = !valid_0 || advance_0.
   always_comb begin
      ld[LAST] = !v_q[LAST] || out_ready;
      for (int k = LAST - 1; k >= 0; k--) begin
         ld[k] = !v_q[k] || ld[k+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            s_q[k]  <= '0;
            xr_q[k] <= '0;
            yr_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               v_q[k] <= f_v[k];
               if (f_v[k]) begin
                  c_q[k]  <= n_c[k];
                  s_q[k]  <= n_s[k];
                  xr_q[k] <= n_x[k];
                  yr_q[k] <= n_y[k];
               end
            end
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[LAST];
   assign s         = s_q[LAST];
   assign co        = c_q[LAST];

`ifdef PIPELINED_ADDER_OVF_EN
   logic xs_q [STAGES];
   logic ys_q [STAGES];
   logic f_xs [STAGES];
   logic f_ys [STAGES];

   always_comb begin
      f_xs[0] = x[WIDTH-1];
      f_ys[0] = f_y[0][WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
         f_xs[k] = xs_q[k-1];
         f_ys[k] = ys_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            xs_q[k] <= 1'b0;
            ys_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k] && f_v[k]) begin
               xs_q[k] <= f_xs[k];
               ys_q[k] <= f_ys[k];
            end
         end
      end
   end

   // Same-sign operands producing a result of the other sign.
   assign ovf = (xs_q[LAST] == ys_q[LAST]) && (s_q[LAST][WIDTH-1] != xs_q[LAST]);
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=32, STAGES=4): directed literal vectors plus
// randomized traffic scored against an arithmetic reference model.
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int N = 4;
`ifdef PIPELINED_ADDER_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         ci;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         co;
   logic         ovf;

   pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int tests   = 0;
   int fails   = 0;
   int acc_cnt = 0;
   int del_cnt = 0;
   logic [W+1:0] exp_q [$];
   logic         stall_prev = 1'b0;
   logic [W+1:0] stall_val  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: {ovf, co, s} straight from the arithmetic definition.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic m);
      logic [W-1:0] yi;
      logic [W:0]   sum;
      logic         v;
      yi  = m ? ~b : b;
      sum = {1'b0, a} + {1'b0, yi} + {{W{1'b0}}, (m ? ~c : c)};
      v   = OVF_ON && (a[W-1] == yi[W-1]) && (sum[W-1] != a[W-1]);
      return {v, sum};
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (stall_prev && out_valid)
            check("stall_hold", {ovf, co, s}, stall_val);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               check("result", {ovf, co, s}, exp_q.pop_front());
               del_cnt++;
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_val  = {ovf, co, s};
         if (in_valid && in_ready) begin
            exp_q.push_back(model(x, y, ci, sub));
            acc_cnt++;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic civ, input logic subv);
      in_valid = 1'b1;
      x        = xv;
      y        = yv;
      ci       = civ;
      sub      = subv;
   endtask

   task automatic directed(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                           input logic civ, input logic subv, input logic [W-1:0] es,
                           input logic eco, input logic eovf);
      int lat;
      out_ready = 1'b1;
      drive(xv, yv, civ, subv);
      check({name, "_in_ready"}, in_ready, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end
      check({name, "_latency"}, lat, N);
      check({name, "_s"}, s, es);
      check({name, "_co"}, co, eco);
      check({name, "_ovf"}, ovf, eovf && OVF_ON);
      step();
   endtask

   task automatic wait_drain(input string name);
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      step();
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int a0;
      int d0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x = '0; y = '0; ci = 1'b0; sub = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("reset_out_valid", out_valid, 0);
      check("reset_s", s, 0);
      check("reset_co", co, 0);
      check("reset_ovf", ovf, 0);
      check("reset_in_ready", in_ready, 1);

      directed("carry_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      directed("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      directed("sub_borrow", 32'h7, 32'h5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
      directed("neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      wait_drain("directed_drain");

      // Back-to-back stream at full rate.
      d0 = del_cnt;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("stream_in_ready", in_ready, 1);
         step();
      end
      wait_drain("stream_drain");
      check("stream_count", del_cnt - d0, 100);

      // Full pipe with consumer stalled.
      a0 = acc_cnt;
      d0 = del_cnt;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
      end
      check("stall_accepted", acc_cnt - a0, N);
      check("stall_in_ready", in_ready, 0);
      wait_drain("stall_drain");
      check("stall_delivered", del_cnt - d0, N);

      // Random valid/ready traffic on both sides.
      d0 = del_cnt;
      a0 = acc_cnt;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            in_valid = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      wait_drain("mixed_drain");
      check("mixed_count", del_cnt - d0, acc_cnt - a0);

      // Reset with beats in flight, one of them already at the output.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive($urandom | 32'h1, $urandom | 32'h1, 1'b1, 1'b0);
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      check("pre_reset_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_s", s, 0);
      check("midrst_co", co, 0);
      check("midrst_ovf", ovf, 0);
      repeat (2) step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("post_reset_quiet", out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
